// File: rtl/rast_sched_pkg.sv
// Shared parameters, state encoding and reset constants for the rast triangle
// scheduler and its sub-blocks.
package rast_sched_pkg;

  localparam int SIGFIG    = 24;
  localparam int RADIX     = 10;
  localparam int VERTS     = 3;
  localparam int AXIS      = 3;
  localparam int COLORS    = 3;
  localparam int NREQ_DEF  = 2;
  localparam int DRAIN_DEF = 16;

  localparam logic [3:0] SUBSAMPLE_RST = 4'b1000;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    CFG
  } rast_sched_state_e;

endpackage

// File: rtl/rast_sched_if.sv
// Bundle of requester, configuration and rast-facing signals of rast_sched.
// The slave modport is the scheduler; master is whoever drives it.
interface rast_sched_if
  import rast_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req_valid[i] must not depend on req_ready[i]; a triangle moves
  // from requester i on any cycle where both are high. cfg_valid is held until
  // the cycle cfg_ready is high, and rast takes the R10 triangle on any cycle
  // where validTri_R10H and halt_RnnnnL are both high.
  logic [NREQ-1:0]                                  req_valid;
  logic [NREQ-1:0]                                  req_ready;
  logic [NREQ-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri;
  logic [NREQ-1:0][COLORS-1:0][SIGFIG-1:0]          req_color;
  logic [NREQ-1:0]                                  req_cull;

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [1:0][SIGFIG-1:0] cfg_screen;
  logic [3:0]            cfg_subsample;

  logic                                  halt_RnnnnL;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R10U;
  logic                                  validTri_R10H;
  logic                                  to_cull;
  logic [1:0][SIGFIG-1:0]                 screen_RnnnnS;
  logic [3:0]                            subSample_RnnnnU;
  logic [IDW-1:0]                        grant_id;
  logic                                  busy;
  rast_sched_state_e                     dbg_state;

  modport slave (
    input  req_valid, req_tri, req_color, req_cull,
    input  cfg_valid, cfg_screen, cfg_subsample, halt_RnnnnL,
    output req_ready, cfg_ready, tri_R10S, color_R10U, validTri_R10H, to_cull,
    output screen_RnnnnS, subSample_RnnnnU, grant_id, busy, dbg_state
  );

  modport master (
    output req_valid, req_tri, req_color, req_cull,
    output cfg_valid, cfg_screen, cfg_subsample, halt_RnnnnL,
    input  req_ready, cfg_ready, tri_R10S, color_R10U, validTri_R10H, to_cull,
    input  screen_RnnnnS, subSample_RnnnnU, grant_id, busy, dbg_state
  );

endinterface

// File: rtl/rast_sched_rr_arbiter.sv
// Round-robin arbiter: searches from ptr+1 upward (wrapping) and returns the
// first requesting index as both one-hot grant and binary index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] p, input int k);
    return IDW'((int'(p) + k) % NREQ);
  endfunction

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    // k = NREQ wraps back to ptr itself, so the last winner is searched last.
    for (int k = 1; k <= NREQ; k++) begin
      if (!any && req[wrap_idx(ptr, k)]) begin
        any                  = 1'b1;
        gnt[wrap_idx(ptr, k)] = 1'b1;
        idx                  = wrap_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/rast_sched.sv
// Triangle scheduler in front of rast: round-robin requester arbitration into
// a one-deep R10 output register, plus drain-gated screen/subsample updates.
module rast_sched #(
  parameter int NREQ  = rast_sched_pkg::NREQ_DEF,
  parameter int DRAIN = rast_sched_pkg::DRAIN_DEF
) (
  input logic        clk,
  input logic        rst,
  rast_sched_if.slave bus
);
  import rast_sched_pkg::SIGFIG;
  import rast_sched_pkg::VERTS;
  import rast_sched_pkg::AXIS;
  import rast_sched_pkg::COLORS;
  import rast_sched_pkg::SUBSAMPLE_RST;
  import rast_sched_pkg::rast_sched_state_e;
  import rast_sched_pkg::RUN;
  import rast_sched_pkg::CFG;

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(DRAIN + 1);

  typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0]          color_t;
  typedef logic [1:0][SIGFIG-1:0]                 screen_t;

  rast_sched_state_e state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic              or_valid_q, or_valid_d;
  tri_t              or_tri_q, or_tri_d;
  color_t            or_color_q, or_color_d;
  logic              or_cull_q, or_cull_d;
  logic [IDW-1:0]    or_id_q, or_id_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  screen_t           screen_q, screen_d;
  logic [3:0]        sub_q, sub_d;

  logic [NREQ-1:0] arb_gnt;
  logic [NREQ-1:0] req_ready_c;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;
  logic            accepted;
  logic            load_en;
  logic            cfg_ready_c;

  // The OR may reload in the same cycle rast takes its current triangle.
  assign accepted = or_valid_q & bus.halt_RnnnnL;
  assign load_en  = ~or_valid_q | accepted;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(bus.req_valid),
    .ptr(ptr_q),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    or_valid_d  = or_valid_q;
    or_tri_d    = or_tri_q;
    or_color_d  = or_color_q;
    or_cull_d   = or_cull_q;
    or_id_d     = or_id_q;
    cnt_d       = cnt_q;
    screen_d    = screen_q;
    sub_d       = sub_q;
    req_ready_c = '0;
    cfg_ready_c = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.cfg_valid) begin
          // Pending config starves all requesters until the OR has emptied.
          if (load_en) begin
            or_valid_d = 1'b0;
            state_d    = rast_sched_pkg::DRAIN;
            cnt_d      = CW'(DRAIN);
          end
        end else if (load_en) begin
          if (arb_any) begin
            req_ready_c = arb_gnt;
            or_valid_d  = 1'b1;
            or_tri_d    = bus.req_tri[arb_idx];
            or_color_d  = bus.req_color[arb_idx];
            or_cull_d   = bus.req_cull[arb_idx];
            or_id_d     = arb_idx;
            ptr_d       = arb_idx;
          end else begin
            or_valid_d = 1'b0;
          end
        end
      end
      rast_sched_pkg::DRAIN: begin
        // Only an unbroken run of DRAIN halt-high cycles proves rast is empty.
        if (!bus.halt_RnnnnL) begin
          cnt_d = CW'(DRAIN);
        end else if (cnt_q == CW'(1)) begin
          state_d  = CFG;
          screen_d = bus.cfg_screen;
          sub_d    = bus.cfg_subsample;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CFG: begin
        cfg_ready_c = 1'b1;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      ptr_q      <= IDW'(NREQ - 1);
      or_valid_q <= 1'b0;
      or_tri_q   <= '0;
      or_color_q <= '0;
      or_cull_q  <= 1'b0;
      or_id_q    <= '0;
      cnt_q      <= '0;
      screen_q   <= '0;
      sub_q      <= SUBSAMPLE_RST;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      or_valid_q <= or_valid_d;
      or_tri_q   <= or_tri_d;
      or_color_q <= or_color_d;
      or_cull_q  <= or_cull_d;
      or_id_q    <= or_id_d;
      cnt_q      <= cnt_d;
      screen_q   <= screen_d;
      sub_q      <= sub_d;
    end
  end

  assign bus.req_ready        = rst ? req_ready_c : '0;
  assign bus.cfg_ready        = cfg_ready_c;
  assign bus.tri_R10S         = or_tri_q;
  assign bus.color_R10U       = or_color_q;
  assign bus.validTri_R10H    = or_valid_q;
  assign bus.to_cull          = or_cull_q;
  assign bus.grant_id         = or_id_q;
  assign bus.screen_RnnnnS    = screen_q;
  assign bus.subSample_RnnnnU = sub_q;
  assign bus.busy             = (state_q != RUN) | or_valid_q;
  assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_rast_sched.sv
// Bench for rast_sched: randomized requesters, halt and config traffic checked
// each cycle against a behavioural model, plus directed literal checks.
module tb_rast_sched;
  import rast_sched_pkg::*;

  localparam int NRQ   = 2;
  localparam int DRN   = 16;
  localparam int IDW   = 1;
  localparam int TRI_W = VERTS * AXIS * SIGFIG;
  localparam int COL_W = COLORS * SIGFIG;
  localparam int SB_W  = TRI_W + COL_W + 1 + IDW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rast_sched_if #(.NREQ(NRQ)) bus ();

  rast_sched #(.NREQ(NRQ), .DRAIN(DRN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  bit               m_full;
  logic [TRI_W-1:0] m_tri;
  logic [COL_W-1:0] m_col;
  logic             m_cull;
  int               m_id, m_last, m_mode, m_run;
  logic [47:0]      m_screen;
  logic [3:0]       m_sub;

  logic [SB_W-1:0] exp_q[$];
  int n_in = 0, n_out = 0, n_drop = 0;

  int              w;
  bit              acc, free;
  logic [NRQ-1:0]  exp_ready;
  logic [IDW-1:0]  wi;
  logic [SB_W-1:0] item;

  always @(negedge clk) begin
    if (!rst) begin
      m_full = 0; m_last = NRQ - 1; m_mode = 0; m_run = 0;
      m_screen = '0; m_sub = 4'b1000;
      n_drop += exp_q.size();
      exp_q.delete();
      chk("rst_valid", 320'(bus.validTri_R10H), 0);
      chk("rst_tri", 320'(bus.tri_R10S), 0);
      chk("rst_color", 320'(bus.color_R10U), 0);
      chk("rst_cull", 320'(bus.to_cull), 0);
      chk("rst_grant", 320'(bus.grant_id), 0);
      chk("rst_screen", 320'(bus.screen_RnnnnS), 0);
      chk("rst_sub", 320'(bus.subSample_RnnnnU), 320'(4'b1000));
      chk("rst_cfg_ready", 320'(bus.cfg_ready), 0);
      chk("rst_req_ready", 320'(bus.req_ready), 0);
      chk("rst_busy", 320'(bus.busy), 0);
    end else begin
      acc  = m_full && bus.halt_RnnnnL;
      free = !m_full || acc;
      w = -1;
      exp_ready = '0;
      if (m_mode == 0 && !bus.cfg_valid && free)
        for (int k = 1; k <= NRQ; k++)
          if (w < 0 && bus.req_valid[(m_last + k) % NRQ]) w = (m_last + k) % NRQ;
      if (w >= 0) exp_ready[w] = 1'b1;

      chk("valid", 320'(bus.validTri_R10H), 320'(m_full));
      if (m_full) begin
        chk("tri", 320'(bus.tri_R10S), 320'(m_tri));
        chk("color", 320'(bus.color_R10U), 320'(m_col));
        chk("cull", 320'(bus.to_cull), 320'(m_cull));
        chk("grant", 320'(bus.grant_id), 320'(m_id));
      end
      chk("req_ready", 320'(bus.req_ready), 320'(exp_ready));
      chk("cfg_ready", 320'(bus.cfg_ready), 320'(m_mode == 2));
      chk("screen", 320'(bus.screen_RnnnnS), 320'(m_screen));
      chk("sub", 320'(bus.subSample_RnnnnU), 320'(m_sub));
      chk("busy", 320'(bus.busy), 320'(m_mode != 0 || m_full));

      // rast-side pop first (current OR), then requester-side pushes.
      if (bus.validTri_R10H && bus.halt_RnnnnL) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb_underflow: got triangle with id %0d expected none", bus.grant_id);
        end else begin
          item = exp_q.pop_front();
          chk("sb_order", 320'({bus.tri_R10S, bus.color_R10U, bus.to_cull, bus.grant_id}), 320'(item));
        end
      end
      for (int i = 0; i < NRQ; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          wi = IDW'(i);
          exp_q.push_back({bus.req_tri[i], bus.req_color[i], bus.req_cull[i], wi});
          n_in++;
        end

      case (m_mode)
        0: begin
          if (bus.cfg_valid) begin
            if (free) begin m_full = 0; m_mode = 1; m_run = 0; end
          end else if (free) begin
            if (w >= 0) begin
              wi = IDW'(w);
              m_full = 1; m_tri = bus.req_tri[wi]; m_col = bus.req_color[wi];
              m_cull = bus.req_cull[wi]; m_id = w; m_last = w;
            end else m_full = 0;
          end
        end
        1: begin
          if (bus.halt_RnnnnL) begin
            m_run++;
            if (m_run >= DRN) begin
              m_mode = 2; m_screen = bus.cfg_screen; m_sub = bus.cfg_subsample;
            end
          end else m_run = 0;
        end
        default: m_mode = 0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  logic [NRQ-1:0] en = '0;
  bit             cont = 0;
  int             halt_mode = 0;  // 0 high, 1 low, 2 random, 3 manual
  bit             rand_cfg = 0;
  logic [NRQ-1:0] fired = '0;
  bit             cfg_fired = 0;

  logic [NRQ-1:0] smp_ready;
  logic           smp_valid, smp_cfg_ready;
  logic [IDW-1:0] smp_grant;
  logic [47:0]    smp_screen;
  logic [3:0]     smp_sub;

  task automatic new_tri(input int i);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) bus.req_tri[i][v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++) bus.req_color[i][c] = SIGFIG'($urandom);
    bus.req_cull[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive();
    for (int i = 0; i < NRQ; i++) begin
      if (!en[i]) bus.req_valid[i] = 1'b0;
      else if (!bus.req_valid[i] || fired[i]) begin
        new_tri(i);
        bus.req_valid[i] = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
    case (halt_mode)
      0: bus.halt_RnnnnL = 1'b1;
      1: bus.halt_RnnnnL = 1'b0;
      2: bus.halt_RnnnnL = ($urandom_range(0, 19) != 0);
      default: ;
    endcase
    if (bus.cfg_valid && cfg_fired) bus.cfg_valid = 1'b0;
    else if (rand_cfg && !bus.cfg_valid && $urandom_range(0, 59) == 0) begin
      bus.cfg_valid     = 1'b1;
      bus.cfg_screen    = {SIGFIG'($urandom), SIGFIG'($urandom)};
      bus.cfg_subsample = 4'b0001 << $urandom_range(0, 3);
    end
  endtask

  task automatic step();
    @(negedge clk);
    smp_ready = bus.req_ready; smp_valid = bus.validTri_R10H; smp_grant = bus.grant_id;
    smp_cfg_ready = bus.cfg_ready; smp_screen = bus.screen_RnnnnS; smp_sub = bus.subSample_RnnnnU;
    fired = bus.req_valid & bus.req_ready;
    cfg_fired = bus.cfg_ready;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic cfg_run(input logic [47:0] scr, input logic [3:0] sub, input int low_from,
                         input int low_to, input int exp_first, input string tag);
    int first = -1, pulses = 0, ready_hits = 0;
    bus.cfg_valid = 1'b1; bus.cfg_screen = scr; bus.cfg_subsample = sub;
    halt_mode = 3;
    for (int s = 0; s < exp_first + 4; s++) begin
      bus.halt_RnnnnL = !(s >= low_from && s <= low_to);
      step();
      if (smp_cfg_ready) begin
        pulses++;
        if (first < 0) begin
          first = s;
          chk({tag, "_screen"}, 320'(smp_screen), 320'(scr));
          chk({tag, "_sub"}, 320'(smp_sub), 320'(sub));
        end
      end
      if (s <= exp_first && smp_ready != 0) ready_hits++;
    end
    halt_mode = 0;
    chk({tag, "_cycle"}, 320'(first), 320'(exp_first));
    chk({tag, "_pulses"}, 320'(pulses), 1);
    chk({tag, "_blocked"}, 320'(ready_hits), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = '0; bus.req_tri = '0; bus.req_color = '0; bus.req_cull = '0;
    bus.cfg_valid = 1'b0; bus.cfg_screen = '0; bus.cfg_subsample = 4'b1000;
    bus.halt_RnnnnL = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // round-robin with both requesters always valid
    en = 2'b11; cont = 1; drive();
    step();
    chk("rr_first_ready", 320'(smp_ready), 320'(2'b01));
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_grant", 320'(smp_grant), 320'(k % 2));
      chk("rr_valid", 320'(smp_valid), 1);
    end

    // back-pressure with OR full
    bus.halt_RnnnnL = 1'b0; halt_mode = 1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) halt_mode = 0;
      step();
      chk("bp_ready", 320'(smp_ready), 0);
      chk("bp_valid", 320'(smp_valid), 1);
    end

    // random traffic with occasional config changes
    cont = 0; halt_mode = 2; rand_cfg = 1;
    repeat (400) step();
    rand_cfg = 0; halt_mode = 0;
    for (int k = 0; k < 100 && bus.cfg_valid; k++) step();
    chk("cfg_settle", 320'(bus.cfg_valid), 0);

    // directed drain, halt high throughout
    cont = 1; repeat (3) step();
    cfg_run({24'd640, 24'd480}, 4'b0010, 100, 100, DRN + 1, "drain");

    // drain restart: halt low in cycles 6..8, then 16 halt-high cycles
    repeat (2) step();
    cfg_run({24'd1920, 24'd1080}, 4'b0100, 6, 8, 9 + DRN, "restart");

    // only requester 1 active
    en = 2'b10; cont = 0; halt_mode = 2; bus.req_valid[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("single_idle_ready", 320'(smp_ready[0]), 0);
      if (k > 2 && smp_valid) chk("single_grant", 320'(smp_grant), 1);
    end

    // reset mid-stream
    en = 2'b11; cont = 1; halt_mode = 0;
    repeat (5) step();
    #2 rst = 1'b0;
    step();
    chk("mid_rst_valid", 320'(smp_valid), 0);
    chk("mid_rst_sub", 320'(smp_sub), 320'(4'b1000));
    rst = 1'b1;
    step();
    chk("post_rst_ready", 320'(smp_ready), 320'(2'b01));
    repeat (10) step();

    // drain out and reconcile counts
    en = '0; bus.req_valid = '0;
    repeat (5) step();
    chk("sb_empty", 320'(exp_q.size()), 0);
    chk("sb_count", 320'(n_in), 320'(n_out + n_drop));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rast_sched.md
# rast_sched

Triangle scheduler and configuration sequencer in front of the `rast` core. It arbitrates round-robin between NREQ triangle producers and registers the winner onto the rast R10 input bus, honouring rast's `halt_RnnnnL` back-pressure. It also applies screen/subsample configuration changes only after the rast pipeline has drained.

## Interface
- SIGFIG, 24, bits per coordinate/color
- RADIX, 10, fraction bits (pass-through only)
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, color channels
- NREQ, 2, triangle requesters (2..8)
- DRAIN, 16, halt-high cycles required before config may change (≥ total rast pipe depth)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  [NREQ]  requester i has a triangle
- req_ready  out  [NREQ]  triangle from requester i taken this cycle
- req_tri  in  [NREQ][VERTS][AXIS]×SIGFIG signed  vertex data
- req_color  in  [NREQ][COLORS]×SIGFIG unsigned  color
- req_cull  in  [NREQ]  backface-cull enable for this triangle
- cfg_valid  in  1  new configuration pending; held until cfg_ready
- cfg_ready  out  1  configuration latched this cycle
- cfg_screen  in  [2]×SIGFIG signed  new screen size
- cfg_subsample  in  4  new subsample interval (one-hot)
- halt_RnnnnL  in  1  from rast; low = rast not accepting
- tri_R10S  out  [VERTS][AXIS]×SIGFIG  to rast
- color_R10U  out  [COLORS]×SIGFIG  to rast
- validTri_R10H  out  1  to rast
- to_cull  out  1  to rast
- screen_RnnnnS  out  [2]×SIGFIG  to rast
- subSample_RnnnnU  out  4  to rast
- grant_id  out  $clog2(NREQ)  source index of triangle on R10 bus
- busy  out  1  state≠RUN or validTri_R10H

## Operation
- Output register (OR) holds one triangle. It is accepted by rast on any cycle with validTri_R10H=1 and halt_RnnnnL=1.
- load_en = OR empty, or OR accepted this cycle.
- States:
  - RUN
    - cfg_valid=0 and load_en: the round-robin arbiter picks the first valid requester starting at ptr+1 (mod NREQ).
    - req_ready is asserted only for that index. The OR loads its tri/color/cull/grant_id, and ptr becomes the winner.
    - No valid requester with load_en: OR clears (validTri_R10H←0).
    - cfg_valid=1 blocks all req_ready. Transition to DRAIN when the OR is empty or accepted this cycle.
  - DRAIN
    - cnt loads DRAIN on entry.
    - Decrements each cycle halt_RnnnnL=1; reloads DRAIN when halt_RnnnnL=0.
    - cnt=1 with halt high → CFG.
  - CFG (one cycle): cfg_ready=1; screen_RnnnnS/subSample_RnnnnU ← cfg_*; → RUN.
- req_ready is purely combinational from req_valid, state, OR status and halt_RnnnnL. A requester must not make req_valid depend on req_ready.
- Config outputs are stable except on the CFG cycle.
- Reset values:
  - state=RUN, ptr=NREQ-1 (requester 0 wins first)
  - validTri_R10H=0; tri/color/to_cull/grant_id=0
  - screen_RnnnnS=0; subSample_RnnnnU=4'b1000
  - cfg_ready=0; req_ready=0; busy=0
- Reset asserted mid-operation: the OR triangle and any DRAIN progress are discarded; no partial config is applied.

## Timing
- Requester handshake → validTri_R10H one cycle later.
- Throughput is one triangle per cycle while halt_RnnnnL=1: accept and reload happen in the same cycle.
- halt_RnnnnL low: OR contents and validTri_R10H hold unchanged; req_ready=0 if the OR is full.
- Config latency from cfg_valid rise, assuming the OR is empty and halt stays high: 1 (RUN→DRAIN) + DRAIN cycles + CFG cycle. cfg_ready occurs at cycle DRAIN+1 after cfg_valid is sampled.
- Simultaneous cfg_valid and req_valid in RUN: config wins; no triangle is granted that cycle.

## Structure
- Add to rast_params:
  - NREQ and DRAIN defaults
  - typedef enum logic [1:0] {RUN, DRAIN, CFG} rast_sched_state_e
  - SUBSAMPLE_RST = 4'b1000
- Sub-module `rr_arbiter` (NREQ-wide, ptr input, one-hot grant and index output). The rest is flat.

## Test plan
- Reset: rst=0 mid-stream → all outputs at their listed reset values on the next clock edge; subSample_RnnnnU=4'b1000.
- Round-robin: both requesters valid continuously, halt high → grant_id sequence 0,1,0,1; validTri_R10H high every cycle.
- Back-pressure: halt_RnnnnL low for 5 cycles with the OR full → tri_R10S stable, req_ready=0, no triangle lost or duplicated. Scoreboard count in = out.
- Config drain, DRAIN=16, halt high: cfg_valid raised → no req_ready for 17 cycles, cfg_ready pulses once, screen_RnnnnS updates on that cycle.
- Drain restart: halt low for 3 cycles mid-DRAIN → cnt reloads; cfg_ready appears 16 halt-high cycles after halt returns high.
- Single requester: only req_valid[1] asserted → grant_id=1 every triangle; the idle requester never receives req_ready.
